eth_dataplane_top: RTL and testbench

//  PL dataplane top: AXI4-Lite slave register block plus AXI-Stream RX sink with an Ethernet II header parser (dst MAC, src MAC, EtherType).
//  PS configures it and reads status over AXI4-Lite; the MAC/DMA feeds frames over AXI-Stream. Frames are consumed, not forwarded.

---
 rtl/eth_dataplane_top.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_eth_dataplane_top.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_dataplane_top.sv
`default_nettype none
// ============================================================================
//  Module      : eth_dataplane_top
//  Description : PL dataplane top. AXI4-Lite slave register block plus an
//                AXI-Stream RX sink that parses the Ethernet II header
//                (destination MAC, source MAC, EtherType) of each frame.
//                Frames are consumed, never forwarded.
//  Ports       : clk/rst_n                - clock, async active-low reset
//                AW*/W*/B*/AR*/R*         - AXI4-Lite slave (32-bit regs)
//                tvalid/tdata/tkeep/tlast - AXI-Stream RX input
//                tready                   - stream ready (= CTRL.RX_EN)
//  Option      : DP_MAC_FILTER_EN - drop frames whose destination is neither
//                MY_MAC nor broadcast; adds MY_MAC_LO/HI at 0x24/0x28.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_dataplane_top #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic                    BREADY,
    output logic                    BVALID,
    output logic [1:0]              BRESP,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic                    RREADY,
    output logic                    RVALID,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    input  logic                    tvalid,
    input  logic [DATA_WIDTH-1:0]   tdata,
    input  logic [DATA_WIDTH/8-1:0] tkeep,
    input  logic                    tlast,
    output logic                    tready
);

    localparam logic [ADDR_WIDTH-1:0] c_CTRL     = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] c_SCRATCH  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] c_DST_LO   = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] c_DST_HI   = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] c_SRC_LO   = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] c_SRC_HI   = ADDR_WIDTH'(8'h14);
    localparam logic [ADDR_WIDTH-1:0] c_ETH_TYPE = ADDR_WIDTH'(8'h18);
    localparam logic [ADDR_WIDTH-1:0] c_FRM_CNT  = ADDR_WIDTH'(8'h1C);
    localparam logic [ADDR_WIDTH-1:0] c_RUNT_CNT = ADDR_WIDTH'(8'h20);
    localparam logic [ADDR_WIDTH-1:0] c_MY_LO    = ADDR_WIDTH'(8'h24);
    localparam logic [ADDR_WIDTH-1:0] c_MY_HI    = ADDR_WIDTH'(8'h28);

    typedef enum logic [1:0] {S_HDR0 = 2'd0, S_HDR1 = 2'd1, S_PAYLOAD = 2'd2} state_t;

    // r_live stays low during reset and for the first cycle after release so
    // that every READY output is 0 while reset is asserted.
    logic                  r_live;
    logic                  r_aw_full, r_w_full, r_bvalid, r_rvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata, r_rdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic                  r_rx_en;
    logic [31:0]           r_scratch;
    logic [47:0]           r_dst_mac, r_src_mac, r_dst_tmp;
    logic [15:0]           r_eth_type, r_src_hi_tmp;
    logic [31:0]           r_frame_cnt, r_runt_cnt;
    logic                  r_bad, r_commit;
    state_t                r_state, w_state_nxt;
`ifdef DP_MAC_FILTER_EN
    logic [31:0]           r_my_lo;
    logic [15:0]           r_my_hi;
`endif

    logic        w_awready, w_wready, w_arready, w_do_write, w_beat;
    logic [31:0] w_rd_data, w_wr_old, w_wr_new;
    logic        w_rd_err, w_wr_err;
    logic        w_hdr1_ok, w_pass, w_commit, w_frame_inc, w_runt_inc;
    logic        w_unused;

    assign w_unused   = &{1'b0, AWPROT, ARPROT};
    assign w_awready  = r_live & ~r_aw_full & ~r_bvalid;
    assign w_wready   = r_live & ~r_w_full  & ~r_bvalid;
    assign w_arready  = r_live & ~r_rvalid;
    assign w_do_write = r_aw_full & r_w_full & ~r_bvalid;
    assign w_beat     = tvalid & tready;

    assign AWREADY = w_awready;
    assign WREADY  = w_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = w_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign tready  = r_rx_en;

    // Read decode, sampled at the AR handshake (old value on a same-cycle write).
    always_comb begin
        w_rd_data = 32'd0;
        w_rd_err  = 1'b0;
        case (ARADDR)
            c_CTRL:     w_rd_data = {31'd0, r_rx_en};
            c_SCRATCH:  w_rd_data = r_scratch;
            c_DST_LO:   w_rd_data = r_dst_mac[31:0];
            c_DST_HI:   w_rd_data = {16'd0, r_dst_mac[47:32]};
            c_SRC_LO:   w_rd_data = r_src_mac[31:0];
            c_SRC_HI:   w_rd_data = {16'd0, r_src_mac[47:32]};
            c_ETH_TYPE: w_rd_data = {16'd0, r_eth_type};
            c_FRM_CNT:  w_rd_data = r_frame_cnt;
            c_RUNT_CNT: w_rd_data = r_runt_cnt;
`ifdef DP_MAC_FILTER_EN
            c_MY_LO:    w_rd_data = r_my_lo;
            c_MY_HI:    w_rd_data = {16'd0, r_my_hi};
`endif
            default:    w_rd_err  = 1'b1;
        endcase
    end

    // Write decode plus byte-strobe merge against the current register value.
    always_comb begin
        w_wr_old = 32'd0;
        w_wr_err = 1'b0;
        case (r_awaddr)
            c_CTRL:     w_wr_old = {31'd0, r_rx_en};
            c_SCRATCH:  w_wr_old = r_scratch;
            c_DST_LO, c_DST_HI, c_SRC_LO, c_SRC_HI,
            c_ETH_TYPE, c_FRM_CNT, c_RUNT_CNT: w_wr_old = 32'd0;
`ifdef DP_MAC_FILTER_EN
            c_MY_LO:    w_wr_old = r_my_lo;
            c_MY_HI:    w_wr_old = {16'd0, r_my_hi};
`endif
            default:    w_wr_err = 1'b1;
        endcase
        for (int i = 0; i < 4; i++) begin
            w_wr_new[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : w_wr_old[8*i +: 8];
        end
    end

    // AXI4-Lite channel handling and RW registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bresp   <= 2'd0;
            r_rresp   <= 2'd0;
            r_rdata   <= 32'd0;
            r_rx_en   <= 1'b0;
            r_scratch <= 32'd0;
`ifdef DP_MAC_FILTER_EN
            r_my_lo   <= 32'd0;
            r_my_hi   <= 16'd0;
`endif
        end else begin
            r_live <= 1'b1;
            if (!r_live) begin
                r_rx_en <= 1'b1;    // RX enabled by default once out of reset
            end
            if (AWVALID && w_awready) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= AWADDR;
            end
            if (WVALID && w_wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
            end
            if (w_do_write) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? 2'b10 : 2'b00;
                case (r_awaddr)
                    c_CTRL:    r_rx_en   <= w_wr_new[0];
                    c_SCRATCH: r_scratch <= w_wr_new;
`ifdef DP_MAC_FILTER_EN
                    c_MY_LO:   r_my_lo   <= w_wr_new;
                    c_MY_HI:   r_my_hi   <= w_wr_new[15:0];
`endif
                    default: ;
                endcase
            end else if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (ARVALID && w_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
            end else if (r_rvalid && RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

`ifdef DP_MAC_FILTER_EN
    assign w_pass = (r_dst_tmp == {r_my_hi, r_my_lo}) || (r_dst_tmp == 48'hFFFF_FFFF_FFFF);
`else
    assign w_pass = 1'b1;
`endif

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Parser next state and per-beat decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_hdr1_ok   = ~r_bad && (tkeep[5:0] == 6'h3F);
        w_commit    = 1'b0;
        w_frame_inc = 1'b0;
        w_runt_inc  = 1'b0;
        if (w_beat) begin
            case (r_state)
                S_HDR0: begin
                    w_state_nxt = tlast ? S_HDR0 : S_HDR1;
                    w_runt_inc  = tlast;
                end
                S_HDR1: begin
                    w_state_nxt = tlast ? S_HDR0 : S_PAYLOAD;
                    w_commit    = w_hdr1_ok & w_pass;
                    w_frame_inc = tlast & w_hdr1_ok & w_pass;
                    w_runt_inc  = tlast & ~w_hdr1_ok;
                end
                S_PAYLOAD: begin
                    w_state_nxt = tlast ? S_HDR0 : S_PAYLOAD;
                    w_frame_inc = tlast & r_commit;
                    w_runt_inc  = tlast & r_bad;
                end
                default: w_state_nxt = S_HDR0;
            endcase
        end
    end

    // Header capture, field commit and counters. r_bad marks a malformed
    // frame; r_commit marks a frame whose fields were committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_tmp    <= 48'd0;
            r_src_hi_tmp <= 16'd0;
            r_bad        <= 1'b0;
            r_commit     <= 1'b0;
            r_dst_mac    <= 48'd0;
            r_src_mac    <= 48'd0;
            r_eth_type   <= 16'd0;
            r_frame_cnt  <= 32'd0;
            r_runt_cnt   <= 32'd0;
        end else begin
            if (w_beat && r_state == S_HDR0) begin
                r_dst_tmp    <= {tdata[7:0], tdata[15:8], tdata[23:16],
                                 tdata[31:24], tdata[39:32], tdata[47:40]};
                r_src_hi_tmp <= {tdata[55:48], tdata[63:56]};
                r_bad        <= (tkeep != 8'hFF);
                r_commit     <= 1'b0;
            end
            if (w_beat && r_state == S_HDR1) begin
                r_bad    <= ~w_hdr1_ok;
                r_commit <= w_commit;
            end
            if (w_commit) begin
                r_dst_mac  <= r_dst_tmp;
                r_src_mac  <= {r_src_hi_tmp, tdata[7:0], tdata[15:8], tdata[23:16], tdata[31:24]};
                r_eth_type <= {tdata[39:32], tdata[47:40]};
            end
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (w_runt_inc) begin
                r_runt_cnt <= r_runt_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_dataplane_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_dataplane_top
//  Description : Directed self-checking bench for eth_dataplane_top
//                (default build, MAC filter disabled).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_dataplane_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BREADY, BVALID;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RREADY, RVALID;
    logic        tvalid, tlast, tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    int tests = 0;
    int fails = 0;
    logic [1:0]  resp;
    logic [31:0] rd;

    always #5 clk = ~clk;

    eth_dataplane_top #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP),
        .tvalid(tvalid), .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tready(tready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold, output logic [1:0] r);
        int n;
        logic aw_go, w_go;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0; n = 0;
        while ((AWVALID || WVALID) && n < 50) begin
            aw_go = AWREADY; w_go = WREADY;
            @(posedge clk); #1;
            if (aw_go) AWVALID = 1'b0;
            if (w_go)  WVALID  = 1'b0;
            n++;
        end
        while (!BVALID && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            timeout("axi_write");
            AWVALID = 1'b0; WVALID = 1'b0; r = 2'b11;
            return;
        end
        r = BRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", BVALID, 1);
            check("bresp_hold", BRESP, r);
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int hold,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        logic ar_go;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0; n = 0;
        while (ARVALID && n < 50) begin
            ar_go = ARREADY;
            @(posedge clk); #1;
            if (ar_go) ARVALID = 1'b0;
            n++;
        end
        while (!RVALID && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            timeout("axi_read");
            ARVALID = 1'b0; d = 32'hX; r = 2'b11;
            return;
        end
        d = RDATA; r = RRESP;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rvalid_hold", RVALID, 1);
            check("rdata_hold", RDATA, d);
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1; n = 0;
        while (!tready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) timeout("send_beat");
        else begin
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        axi_read(addr, 0, rd, resp);
        check(tag, rd, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        WDATA = 0; WSTRB = 0; tvalid = 0; tdata = 0; tkeep = 0; tlast = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_tready", tready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rx_default_tready", tready, 1);
        rd_check("ctrl_default", 8'h00, 32'h1);

        // Scratch register, byte strobes
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, resp);
        check("scratch_bresp", resp, 2'b00);
        axi_read(8'h04, 0, rd, resp);
        check("scratch_rdata", rd, 32'hDEADBEEF);
        check("scratch_rresp", resp, 2'b00);
        axi_write(8'h04, 32'h00000011, 4'b0001, 0, resp);
        rd_check("scratch_strb", 8'h04, 32'hDEADBE11);

        // Unmapped and read-only accesses
        axi_read(8'h3C, 0, rd, resp);
        check("unmapped_rresp", resp, 2'b10);
        check("unmapped_rdata", rd, 32'h0);
        axi_write(8'h3C, 32'h12345678, 4'hF, 0, resp);
        check("unmapped_bresp", resp, 2'b10);
        axi_write(8'h08, 32'h12345678, 4'hF, 0, resp);
        check("ro_bresp", resp, 2'b00);
        rd_check("ro_unchanged", 8'h08, 32'h0);
        axi_read(8'h24, 0, rd, resp);
        check("mymac_unmapped", resp, 2'b10);

        // Good two-beat frame
        send_beat(64'h3322_FFEE_DDCC_BBAA, 8'hFF, 1'b0);
        send_beat(64'h0000_0008_7766_5544, 8'hFF, 1'b1);
        rd_check("dst_lo", 8'h08, 32'hCCDDEEFF);
        rd_check("dst_hi", 8'h0C, 32'h0000AABB);
        rd_check("src_lo", 8'h10, 32'h44556677);
        rd_check("src_hi", 8'h14, 32'h00002233);
        rd_check("eth_type", 8'h18, 32'h00000800);
        rd_check("frame_cnt_1", 8'h1C, 32'd1);

        // Single-beat runt
        send_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b1);
        rd_check("runt_cnt_1", 8'h20, 32'd1);
        rd_check("runt_dst_kept", 8'h08, 32'hCCDDEEFF);

        // Short HDR1 beat: runt at frame end, no commit
        send_beat(64'h9999_5555_4444_3333, 8'hFF, 1'b0);
        send_beat(64'h0000_0800_1234_5678, 8'h1F, 1'b0);
        send_beat(64'h0, 8'h01, 1'b1);
        rd_check("runt_cnt_2", 8'h20, 32'd2);
        rd_check("frame_cnt_still_1", 8'h1C, 32'd1);
        rd_check("short_src_kept", 8'h10, 32'h44556677);

        // Three-beat good frame
        send_beat(64'h0706_0504_0302_0100, 8'hFF, 1'b0);
        send_beat(64'hFFFF_DD86_0B0A_0908, 8'hFF, 1'b0);
        send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h01, 1'b1);
        rd_check("frame_cnt_2", 8'h1C, 32'd2);
        rd_check("eth_type_2", 8'h18, 32'h000086DD);
        rd_check("src_lo_2", 8'h10, 32'h08090A0B);
        rd_check("src_hi_2", 8'h14, 32'h00000607);
        rd_check("dst_hi_2", 8'h0C, 32'h00000001);
        rd_check("dst_lo_2", 8'h08, 32'h02030405);

        // Backpressure on response channels
        axi_read(8'h04, 3, rd, resp);
        check("stall_rdata", rd, 32'hDEADBE11);
        axi_write(8'h04, 32'h0BADF00D, 4'hF, 3, resp);
        check("stall_bresp", resp, 2'b00);

        // Same-cycle write and read of SCRATCH returns old value
        AWADDR = 8'h04; WDATA = 32'hCAFE0000; WSTRB = 4'hF; ARADDR = 8'h04;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("simul_rvalid", RVALID, 1);
        check("simul_old_value", RDATA, 32'h0BADF00D);
        RREADY = 1'b1; BREADY = 1'b1;
        @(posedge clk); #1;
        check("simul_bvalid", BVALID, 1);
        @(posedge clk); #1;
        RREADY = 1'b0; BREADY = 1'b0;
        rd_check("simul_new_value", 8'h04, 32'hCAFE0000);

        // RX disable
        axi_write(8'h00, 32'h0, 4'hF, 0, resp);
        check("rx_dis_tready", tready, 0);
        axi_write(8'h00, 32'h1, 4'hF, 0, resp);
        check("rx_en_tready", tready, 1);

        // Reset in the middle of a frame
        send_beat(64'h5555_4444_3333_2222, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_tready", tready, 0);
        check("midrst_awready", AWREADY, 0);
        check("midrst_rdata", RDATA, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rd_check("midrst_frame_cnt", 8'h1C, 32'd0);
        rd_check("midrst_scratch", 8'h04, 32'd0);
        send_beat(64'h3322_FFEE_DDCC_BBAA, 8'hFF, 1'b0);
        send_beat(64'h0000_0008_7766_5544, 8'hFF, 1'b1);
        rd_check("post_rst_dst_lo", 8'h08, 32'hCCDDEEFF);
        rd_check("post_rst_type", 8'h18, 32'h00000800);
        rd_check("post_rst_frame_cnt", 8'h1C, 32'd1);
        rd_check("post_rst_runt_cnt", 8'h20, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
